period_meter: RTL and testbench

Measures the period, in `clk` cycles, of a periodic pulse or square wave on `sig_in` and reports each completed measurement with a one-cycle strobe. It is the receive side of the team's free-running wrap counters: a counter that wraps every N cycles and emits a tick produces period = N here. Typical use is in loopback checks of the counter blocks and in measuring external periodic signals.

---
 rtl/period_meter.sv | 83 ++++++++
 tb/tb_period_meter.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/period_meter.sv
// period_meter: measures the period of sig_in in clk cycles, with a one-cycle result strobe
module period_meter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             sig_in,
    output logic [WIDTH-1:0] period,
    output logic             period_valid,
    output logic             overflow,
    output logic             locked
);
    typedef enum logic [1:0] {IDLE, ARM, MEAS} state_t;
    localparam logic [WIDTH-1:0] CNT_MAX = '1;
    state_t state, state_n;
    logic s1, s2, s3, rise;
    logic [WIDTH-1:0] cnt, cnt_n, period_n;
    logic valid_n, overflow_n, locked_n;
    assign rise = s2 & ~s3;
    // two-flop synchronizer plus delay flop for edge detection, independent of en
    always_ff @(posedge clk or posedge reset)
        if (reset) {s1, s2, s3} <= 3'b000;
        else       {s1, s2, s3} <= {sig_in, s1, s2};
    // state and output registers; every output is registered
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state        <= IDLE;
            cnt          <= '0;
            period       <= '0;
            period_valid <= 1'b0;
            overflow     <= 1'b0;
            locked       <= 1'b0;
        end else begin
            state        <= state_n;
            cnt          <= cnt_n;
            period       <= period_n;
            period_valid <= valid_n;
            overflow     <= overflow_n;
            locked       <= locked_n;
        end
    // next state: en low wins over everything, then rise wins over the timeout
    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        period_n   = period;
        valid_n    = 1'b0;
        overflow_n = overflow;
        locked_n   = locked;
        if (!en) begin
            state_n    = IDLE;
            cnt_n      = '0;
            overflow_n = 1'b0;
            locked_n   = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    state_n = ARM;
                    cnt_n   = '0;
                end
                ARM: if (rise) begin
                    state_n = MEAS;
                    cnt_n   = WIDTH'(1);
                end
                MEAS: if (rise) begin
                    period_n   = cnt;
                    valid_n    = 1'b1;
                    locked_n   = 1'b1;
                    overflow_n = 1'b0;
                    cnt_n      = WIDTH'(1);
                end else if (cnt == CNT_MAX) begin
                    overflow_n = 1'b1;
                    locked_n   = 1'b0;
                    cnt_n      = '0;
                    state_n    = ARM;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
                default: state_n = IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_period_meter.sv
// tb_period_meter: directed checks of period_meter with hand-computed expectations
module tb_period_meter;
    logic clk = 1'b0, reset = 1'b1, en = 1'b0, sig_in = 1'b0;
    logic [7:0] period;
    logic period_valid, overflow, locked;
    int checks = 0, errors = 0;
    int nval = 0, last_p = 0, dbl = 0, chg = 0;
    logic prev_v = 1'b0;
    logic [7:0] prev_p = '0;

    period_meter #(.WIDTH(8)) dut (
        .clk(clk), .reset(reset), .en(en), .sig_in(sig_in),
        .period(period), .period_valid(period_valid),
        .overflow(overflow), .locked(locked)
    );

    always #5 clk = ~clk;

    // observe strobes on the falling edge: count them, catch double-wide strobes and stray period changes
    always @(negedge clk) begin
        if (period_valid) begin
            nval = nval + 1;
            last_p = period;
        end
        if (period_valid && prev_v) dbl = dbl + 1;
        if (!reset && !period_valid && period != prev_p) chg = chg + 1;
        prev_v = period_valid;
        prev_p = period;
    end

    task automatic check(input string tag, input int got, input int exp);
        checks = checks + 1;
        if (got != exp) begin
            errors = errors + 1;
            $display("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // n one-cycle pulses with rising edges p cycles apart; ends p cycles after the last rise
    task automatic pulses(input int p, input int n);
        for (int i = 0; i < n; i++) begin
            sig_in = 1'b1;
            cyc(1);
            sig_in = 1'b0;
            cyc(p - 1);
        end
    endtask

    task automatic restart();
        en = 1'b0;
        cyc(2);
        en = 1'b1;
        cyc(2);
        nval = 0;
    endtask

    initial begin
        cyc(2);
        check("rst_period", period, 0);
        check("rst_valid", period_valid, 0);
        check("rst_ovf", overflow, 0);
        check("rst_locked", locked, 0);
        reset = 1'b0;
        cyc(1);

        restart();
        pulses(10, 1);
        check("loop_arm_only", nval, 0);
        check("loop_arm_locked", locked, 0);
        pulses(10, 4);
        check("loop_nval", nval, 4);
        check("loop_period", last_p, 10);
        check("loop_locked", locked, 1);
        check("loop_ovf", overflow, 0);

        restart();
        pulses(2, 6);
        cyc(2);
        check("min_nval", nval, 5);
        check("min_period", last_p, 2);

        restart();
        pulses(255, 3);
        check("b255_nval", nval, 2);
        check("b255_period", last_p, 255);
        check("b255_ovf", overflow, 0);
        check("b255_locked", locked, 1);
        cyc(1);
        sig_in = 1'b1;
        cyc(1);
        check("b256_pre_ovf", overflow, 0);
        check("b256_pre_locked", locked, 1);
        sig_in = 1'b0;
        cyc(1);
        check("b256_ovf", overflow, 1);
        check("b256_locked", locked, 0);
        check("b256_period", period, 255);
        nval = 0;
        cyc(20);
        check("b256_rearm_only", nval, 0);
        check("b256_rearm_ovf", overflow, 1);
        pulses(20, 1);
        check("b256_after_nval", nval, 1);
        check("b256_after_period", last_p, 22);
        check("b256_after_ovf", overflow, 0);
        check("b256_after_locked", locked, 1);

        restart();
        pulses(7, 3);
        check("en_lock_nval", nval, 2);
        check("en_lock_period", last_p, 7);
        en = 1'b0;
        nval = 0;
        sig_in = 1'b1;
        cyc(1);
        sig_in = 1'b0;
        cyc(2);
        check("en_low_period", period, 7);
        check("en_low_locked", locked, 0);
        check("en_low_ovf", overflow, 0);
        check("en_low_nval", nval, 0);
        en = 1'b1;
        pulses(7, 2);
        check("en_re_nval", nval, 1);
        check("en_re_period", last_p, 7);
        check("en_re_locked", locked, 1);

        nval = 0;
        sig_in = 1'b1;
        cyc(1);
        sig_in = 1'b0;
        cyc(1);
        en = 1'b0;
        cyc(1);
        check("sim_en_valid", period_valid, 0);
        check("sim_en_locked", locked, 0);
        cyc(1);
        check("sim_en_nval", nval, 0);

        restart();
        pulses(7, 2);
        check("ar_lock", locked, 1);
        cyc(2);
        #2 reset = 1'b1;
        #1;
        check("ar_period", period, 0);
        check("ar_valid", period_valid, 0);
        check("ar_ovf", overflow, 0);
        check("ar_locked", locked, 0);
        @(posedge clk);
        #3 reset = 1'b0;
        cyc(1);
        nval = 0;
        pulses(7, 1);
        check("ar_first_nval", nval, 0);
        check("ar_first_period", period, 0);
        pulses(7, 1);
        check("ar_second_nval", nval, 1);
        check("ar_second_period", last_p, 7);

        check("strobe_width", dbl, 0);
        check("period_only_with_strobe", chg, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
